// File: rtl/awgn_pkg.sv
// Shared types and constants for the AWGN run-control sequencer.
// The seed floor constants are applied only in builds with AWGN_SEQ_SEED_FIX_EN.
package awgn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEED,
      FILL,
      RUN,
      DRAIN
   } state_t;

   localparam int          NUM_SEEDS  = 6;
   localparam int          SEED_HOLD  = 2;
   localparam logic [31:0] SEED_RESET = 32'hFFFF_FFFF;
   localparam logic [31:0] SEED_MIN_A = 32'd2;
   localparam logic [31:0] SEED_MIN_B = 32'd8;
   localparam logic [31:0] SEED_MIN_C = 32'd16;

   // Each Tausworthe component needs its seed at or above a minimum, or the sequence degenerates.
   function automatic logic [31:0] seedFix(input logic [2:0] idx, input logic [31:0] val);
      logic [31:0] minVal;
      case (idx)
         3'd0, 3'd3: minVal = SEED_MIN_A;
         3'd1, 3'd4: minVal = SEED_MIN_B;
         default:    minVal = SEED_MIN_C;
      endcase
      return (val < minVal) ? (val | minVal) : val;
   endfunction

endpackage

// File: rtl/awgn_seq_if.sv
// Valid/ready sample stream carrying {awgn1, awgn2} pairs out of the sequencer.
interface awgn_seq_if;

   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );

endinterface

// File: rtl/awgn_seq_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module awgn_seq_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 32,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [AW:0]      o_count
);

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == FULL_COUNT);
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // The head is gated so the output reads zero whenever the FIFO is empty.
   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/awgn_seq.sv
// Run-control sequencer for the AWGN core: seed registers, core reset, pipeline fill and sample capture.
// Build option AWGN_SEQ_SEED_FIX_EN forces written seeds up to their legal minimum.
module awgn_seq
   import awgn_pkg::*;
#(
   parameter int FILL_CYCLES = 8,
   parameter int DEPTH       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [31:0] cfg_wdata,
   input  logic        start,
   input  logic [15:0] burst_len,
   input  logic        stop,
   output logic        core_reset,
   output logic [31:0] s0,
   output logic [31:0] s1,
   output logic [31:0] s2,
   output logic [31:0] s3,
   output logic [31:0] s4,
   output logic [31:0] s5,
   input  logic [15:0] awgn1_in,
   input  logic [15:0] awgn2_in,
   awgn_seq_if.master  m_if,
   output logic        busy,
   output logic        done,
   output logic [15:0] drop_cnt
);

   localparam int                 PHASE_W   = $clog2(FILL_CYCLES + SEED_HOLD);
   localparam int                 CNT_W     = $clog2(DEPTH) + 1;
   localparam logic [PHASE_W-1:0] SEED_LAST = PHASE_W'(SEED_HOLD - 1);
   localparam logic [PHASE_W-1:0] FILL_LAST = PHASE_W'(FILL_CYCLES - 1);

   state_t             r_state;
   logic [PHASE_W-1:0] r_phase_cnt;
   logic               r_core_reset;
   logic               r_done;
   logic [15:0]        r_burst_len;
   logic [15:0]        r_sample_cnt;
   logic [15:0]        r_drop_cnt;
   logic [31:0]        r_seed [NUM_SEEDS];

   logic               w_full;
   logic               w_empty;
   logic [CNT_W-1:0]   w_count;
   logic [31:0]        w_head;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic               w_burst_hit;
   logic               w_drain_done;
   logic               w_cfg_write;
   logic [31:0]        w_seed_value;

   assign w_pop  = !w_empty && m_if.m_ready;
   // The core cannot stall: a full FIFO only accepts when the head leaves in the same cycle.
   assign w_push = (r_state == RUN) && (!w_full || m_if.m_ready);
   assign w_drop = (r_state == RUN) && !w_push;

   assign w_burst_hit  = (r_burst_len != 16'd0) && w_push && ((r_sample_cnt + 16'd1) == r_burst_len);
   assign w_drain_done = w_empty || ((w_count == CNT_W'(1)) && w_pop);
   assign w_cfg_write  = cfg_we && (r_state == IDLE) && (cfg_addr < 3'd6);

`ifdef AWGN_SEQ_SEED_FIX_EN
   assign w_seed_value = seedFix(cfg_addr, cfg_wdata);
`else
   assign w_seed_value = cfg_wdata;
`endif

   awgn_seq_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_push),
      .i_data  ({awgn1_in, awgn2_in}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_SEEDS; i++) begin
            r_seed[i] <= SEED_RESET;
         end
      end else if (w_cfg_write) begin
         r_seed[cfg_addr] <= w_seed_value;
      end
   end

   // The drain exits one cycle after the final pop by anticipating the FIFO going empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= IDLE;
         r_phase_cnt  <= '0;
         r_core_reset <= 1'b1;
         r_done       <= 1'b0;
         r_burst_len  <= '0;
         r_sample_cnt <= '0;
         r_drop_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state      <= SEED;
                  r_phase_cnt  <= '0;
                  r_burst_len  <= burst_len;
                  r_sample_cnt <= '0;
                  r_drop_cnt   <= '0;
               end
            end
            SEED: begin
               if (r_phase_cnt == SEED_LAST) begin
                  r_state      <= FILL;
                  r_phase_cnt  <= '0;
                  r_core_reset <= 1'b0;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end
            FILL: begin
               if (r_phase_cnt == FILL_LAST) begin
                  r_state     <= RUN;
                  r_phase_cnt <= '0;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 1'b1;
               end
            end
            RUN: begin
               if (w_push) begin
                  r_sample_cnt <= r_sample_cnt + 16'd1;
               end
               if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                  r_drop_cnt <= r_drop_cnt + 16'd1;
               end
               if (stop || w_burst_hit) begin
                  r_state      <= DRAIN;
                  r_core_reset <= 1'b1;
               end
            end
            DRAIN: begin
               if (w_drain_done) begin
                  r_state <= IDLE;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state      <= IDLE;
               r_core_reset <= 1'b1;
            end
         endcase
      end
   end

   assign m_if.m_valid = !w_empty;
   assign m_if.m_data  = w_head;
   assign core_reset   = r_core_reset;
   assign busy         = (r_state != IDLE);
   assign done         = r_done;
   assign drop_cnt     = r_drop_cnt;
   assign s0           = r_seed[0];
   assign s1           = r_seed[1];
   assign s2           = r_seed[2];
   assign s3           = r_seed[3];
   assign s4           = r_seed[4];
   assign s5           = r_seed[5];

endmodule

// File: tb/tb_awgn_seq.sv
// Scoreboard bench for awgn_seq: a cycle-level reference model predicts captured samples and status,
// a separate monitor checks every delivered beat against the expected queue.
module tb_awgn_seq;

   localparam int FILL    = 8;
   localparam int DEPTH   = 4;
   localparam int P_IDLE  = 0;
   localparam int P_PRE   = 1;
   localparam int P_RUN   = 2;
   localparam int P_DRAIN = 3;

   logic        clk;
   logic        reset;
   logic        cfg_we;
   logic [2:0]  cfg_addr;
   logic [31:0] cfg_wdata;
   logic        start;
   logic [15:0] burst_len;
   logic        stop;
   logic        core_reset;
   logic [31:0] s0, s1, s2, s3, s4, s5;
   logic [15:0] awgn1_in;
   logic [15:0] awgn2_in;
   logic        busy;
   logic        done;
   logic [15:0] drop_cnt;

   awgn_seq_if mIf ();

   awgn_seq #(
      .FILL_CYCLES (FILL),
      .DEPTH       (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .start      (start),
      .burst_len  (burst_len),
      .stop       (stop),
      .core_reset (core_reset),
      .s0         (s0),
      .s1         (s1),
      .s2         (s2),
      .s3         (s3),
      .s4         (s4),
      .s5         (s5),
      .awgn1_in   (awgn1_in),
      .awgn2_in   (awgn2_in),
      .m_if       (mIf),
      .busy       (busy),
      .done       (done),
      .drop_cnt   (drop_cnt)
   );

   int          nTests = 0;
   int          nFail = 0;
   int          cyc = 0;
   int          beatCount = 0;
   bit          randReady = 0;
   logic        readyLevel = 1'b0;
   logic [31:0] pairHist [1024];
   logic [31:0] expSeed [6];
   logic [31:0] expQ [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] seedModel(input int idx, input logic [31:0] v);
`ifdef AWGN_SEQ_SEED_FIX_EN
      if ((idx % 3 == 0) && (v < 32'd2))  return v | 32'd2;
      if ((idx % 3 == 1) && (v < 32'd8))  return v | 32'd8;
      if ((idx % 3 == 2) && (v < 32'd16)) return v | 32'd16;
`endif
      return v;
   endfunction

   // Core outputs and the downstream ready change 2 time units after each rising edge.
   initial begin
      awgn1_in    = '0;
      awgn2_in    = '0;
      mIf.m_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         awgn1_in    = 16'($urandom);
         awgn2_in    = 16'($urandom);
         mIf.m_ready = randReady ? 1'($urandom_range(0, 1)) : readyLevel;
         pairHist[cyc % 1024] = {awgn1_in, awgn2_in};
      end
   end

   // Reference model: sequencing by elapsed cycles, FIFO as an occupancy count.
   initial begin : modelProc
      int          mPhase;
      int          mPre;
      int          mOcc;
      int          mBurst;
      int          mPushed;
      int          mDrop;
      bit          mDonePend;
      bit          pushNow;
      bit          popNow;
      logic [31:0] pushData;
      mPhase = P_IDLE; mPre = 0; mOcc = 0; mBurst = 0; mPushed = 0; mDrop = 0; mDonePend = 0;
      pushData = '0;
      forever begin
         @(negedge clk);
         pushNow = 0;
         if (!reset) begin
            mPhase = P_IDLE; mOcc = 0; mDrop = 0; mDonePend = 0;
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_core_reset", core_reset, 1);
            checkOutput("rst_m_valid", mIf.m_valid, 0);
            checkOutput("rst_m_data", mIf.m_data, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_drop_cnt", drop_cnt, 0);
         end else begin
            checkOutput("busy", busy, mPhase != P_IDLE);
            checkOutput("core_reset", core_reset,
                        (mPhase == P_IDLE) || (mPhase == P_DRAIN) || (mPhase == P_PRE && mPre < 2));
            checkOutput("m_valid", mIf.m_valid, mOcc > 0);
            checkOutput("done", done, mDonePend);
            checkOutput("drop_cnt", drop_cnt, mDrop);
            mDonePend = 0;
            popNow = (mOcc > 0) && mIf.m_ready;
            case (mPhase)
               P_IDLE: begin
                  if (start) begin
                     mPhase = P_PRE; mPre = 0; mBurst = burst_len; mPushed = 0; mDrop = 0;
                  end
               end
               P_PRE: begin
                  if (mPre == 1 + FILL) mPhase = P_RUN;
                  else mPre++;
               end
               P_RUN: begin
                  if (mOcc < DEPTH || mIf.m_ready) begin
                     pushNow  = 1;
                     pushData = {awgn1_in, awgn2_in};
                     mPushed++;
                  end else if (mDrop < 65535) begin
                     mDrop++;
                  end
                  if (stop || (mBurst != 0 && mPushed == mBurst)) mPhase = P_DRAIN;
               end
               default: begin
                  if (mOcc - int'(popNow) == 0) begin
                     mPhase = P_IDLE;
                     mDonePend = 1;
                  end
               end
            endcase
            mOcc = mOcc + int'(pushNow) - int'(popNow);
         end
         @(posedge clk);
         if (pushNow) expQ.push_back(pushData);
      end
   end

   // Monitor: pops the scoreboard on every accepted beat and checks head stability under backpressure.
   initial begin : monitorProc
      bit          prevHold;
      logic [31:0] prevData;
      prevHold = 0;
      prevData = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            prevHold = 0;
            expQ.delete();
         end else begin
            if (prevHold && mIf.m_valid) checkOutput("m_data_hold", mIf.m_data, prevData);
            if (mIf.m_valid && mIf.m_ready) begin
               beatCount++;
               if (expQ.size() == 0) begin
                  nTests++;
                  nFail++;
                  $display("[TB] FAIL beat_unexpected at cycle %0d: got %h, expected no beat", cyc, mIf.m_data);
               end else begin
                  checkOutput("beat_data", mIf.m_data, expQ.pop_front());
               end
            end
            prevHold = mIf.m_valid && !mIf.m_ready;
            prevData = mIf.m_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic toDrive(input int t);
      while (cyc < t) tick();
   endtask

   task automatic toCheck(input int t);
      @(negedge clk);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic writeSeed(input logic [2:0] addr, input logic [31:0] data, input bit store);
      cfg_we    = 1'b1;
      cfg_addr  = addr;
      cfg_wdata = data;
      if (store && addr < 3'd6) expSeed[addr] = seedModel(int'(addr), data);
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic checkSeeds();
      checkOutput("s0", s0, expSeed[0]);
      checkOutput("s1", s1, expSeed[1]);
      checkOutput("s2", s2, expSeed[2]);
      checkOutput("s3", s3, expSeed[3]);
      checkOutput("s4", s4, expSeed[4]);
      checkOutput("s5", s5, expSeed[5]);
   endtask

   task automatic applyStimulus(input logic [15:0] len, input logic withStop, output int s);
      start     = 1'b1;
      burst_len = len;
      stop      = withStop;
      s         = cyc;
      tick();
      start     = 1'b0;
      stop      = 1'b0;
      burst_len = 16'($urandom);
   endtask

   task automatic waitDone(input int base, input int expBeats);
      bit seen;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         nTests++;
         nFail++;
         $display("[TB] FAIL done_timeout at cycle %0d: got no done, expected done within 400 cycles", cyc);
      end
      checkOutput("beat_count", beatCount - base, expBeats);
      checkOutput("busy_at_done", busy, 0);
   endtask

   initial begin
      int s;
      int base;
      int len;
      reset     = 1'b0;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      start     = 1'b0;
      stop      = 1'b0;
      burst_len = '0;
      for (int i = 0; i < 6; i++) expSeed[i] = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      checkSeeds();
      tick();
      reset = 1'b1;
      tick();

      $display("[TB] seeds and 5-beat burst");
      for (int i = 0; i < 6; i++) writeSeed(3'(i), 32'(i + 1), 1);
      writeSeed(3'd7, 32'($urandom), 1);
      @(negedge clk);
      checkSeeds();
      tick();
      readyLevel = 1'b1;
      base = beatCount;
      applyStimulus(16'd5, 1'b0, s);
      toDrive(s + 5);
      writeSeed(3'd0, 32'hA5A5_0000, 0);
      start     = 1'b1;
      burst_len = 16'd9;
      tick();
      start = 1'b0;
      waitDone(base, 5);
      checkOutput("drop_after_burst5", drop_cnt, 0);
      checkSeeds();

      $display("[TB] start-to-first-sample timing");
      tick();
      base = beatCount;
      applyStimulus(16'd3, 1'b0, s);
      toCheck(s + 1);
      checkOutput("busy_c1", busy, 1);
      toCheck(s + 2);
      checkOutput("core_reset_c2", core_reset, 1);
      toCheck(s + 3);
      checkOutput("core_reset_c3", core_reset, 0);
      toCheck(s + 11);
      checkOutput("m_valid_c11", mIf.m_valid, 0);
      toCheck(s + 12);
      checkOutput("m_valid_c12", mIf.m_valid, 1);
      checkOutput("m_data_c12", mIf.m_data, pairHist[(s + 11) % 1024]);
      waitDone(base, 3);

      $display("[TB] backpressure drops, then full push+pop");
      tick();
      readyLevel = 1'b0;
      base = beatCount;
      applyStimulus(16'd10, 1'b0, s);
      toDrive(s + 31);
      readyLevel = 1'b1;
      toCheck(s + 31);
      checkOutput("drop_at_ready_rise", drop_cnt, 16);
      toCheck(s + 32);
      checkOutput("drop_after_full_pushpop", drop_cnt, 16);
      waitDone(base, 10);

      $display("[TB] continuous run with stop; start+stop together");
      tick();
      base = beatCount;
      applyStimulus(16'd0, 1'b1, s);
      toDrive(s + 18);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      waitDone(base, 8);

      $display("[TB] reset during RUN");
      tick();
      readyLevel = 1'b0;
      applyStimulus(16'd0, 1'b0, s);
      toDrive(s + 14);
      reset = 1'b0;
      #1;
      checkOutput("midrst_m_valid", mIf.m_valid, 0);
      checkOutput("midrst_core_reset", core_reset, 1);
      checkOutput("midrst_busy", busy, 0);
      for (int i = 0; i < 6; i++) expSeed[i] = 32'hFFFF_FFFF;
      checkSeeds();
      tick();
      tick();
      reset = 1'b1;
      tick();
      randReady = 1;
      base = beatCount;
      applyStimulus(16'd6, 1'b0, s);
      toCheck(s + 3);
      checkOutput("core_reset_after_rst", core_reset, 0);
      waitDone(base, 6);

      $display("[TB] random bursts with random ready");
      repeat (3) begin
         tick();
         len  = $urandom_range(1, 12);
         base = beatCount;
         applyStimulus(16'(len), 1'b0, s);
         waitDone(base, len);
      end
      tick();
      tick();
      checkOutput("scoreboard_empty", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
